// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling loader.
// Imported by pool_loader and pool_reduce.
package pool_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;
  localparam int   KMAX     = 4;

  function automatic logic [63:0] smin(input int dw);
    smin = 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/pool_reduce.sv
// Window reducer: running signed max and signed sum.
// Result is the max or the kernel-area-scaled sum.
module pool_reduce
  import pool_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          acc,
  input  logic          mode,
  input  logic [2:0]    shamt,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] res
);

  localparam logic [DW-1:0] MINV = DW'(smin(DW));

  logic signed [DW-1:0] mx;
  logic signed [DW+3:0] sm;
  logic signed [DW+3:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= '0;
      sm <= '0;
    end else if (clr) begin
      mx <= MINV;
      sm <= '0;
    end else if (acc) begin
      if ($signed(din) > mx)
        mx <= din;
      sm <= sm + {{4{din[DW-1]}}, din};
    end
  end

  assign sh  = sm >>> shamt;
  assign res = (mode == MODE_AVG) ? sh[DW-1:0] : mx;

endmodule

// File: rtl/pool_loader.sv
// Pooling job sequencer: walks windows, streams taps
// through pool_reduce and writes one result per window.
module pool_loader
  import pool_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 26,
  parameter int DIMW = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic [2:0]      K,
  input  logic [2:0]      S,
  input  logic [DIMW-1:0] C,
  input  logic [DIMW-1:0] H,
  input  logic [DIMW-1:0] W,
  input  logic [AW-1:0]   ifaddr,
  input  logic [AW-1:0]   ofaddr,
  output logic            rvalid,
  output logic [AW-1:0]   raddr,
  input  logic            rready,
  input  logic [31:0]     rdata,
  output logic            wvalid,
  output logic [AW-1:0]   waddr,
  output logic [31:0]     wdata,
  input  logic            wready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int XW = DIMW + 2;
  localparam int PW = 2 * DIMW;

  state_t st, st_nx;

  logic            md;
  logic [2:0]      k_r, s_r;
  logic [DIMW-1:0] c_r, h_r, w_r;
  logic [AW-1:0]   ifa, ofa;
  logic [AW-1:0]   hw, cbase, n;
  logic [DIMW-1:0] ch, hb, wb;
  logic [2:0]      kh, kw;

  logic            rd_ok, wr_ok;
  logic            last_tap, col_more, row_more, last_ch;
  logic            bad, empty;
  logic [DIMW:0]   row, col;
  logic [PW:0]     rowoff;
  logic [PW-1:0]   hw_p;
  logic [2:0]      shamt;
  logic [DW-1:0]   res;
  logic            rdata_unused;

  assign rdata_unused = ^rdata[31:DW];

  assign rd_ok = (st == S_READ) && rready;
  assign wr_ok = (st == S_WRITE) && wready;

  assign last_tap = (kh == k_r - 3'd1)
                 && (kw == k_r - 3'd1);

  // Next window fits while base + S + K <= dimension
  assign col_more = XW'(wb) + XW'(s_r) + XW'(k_r)
                    <= XW'(w_r);
  assign row_more = XW'(hb) + XW'(s_r) + XW'(k_r)
                    <= XW'(h_r);
  assign last_ch  = (ch == c_r - DIMW'(1));

  assign bad = (k_r == 3'd0) || (s_r == 3'd0)
            || (k_r > 3'(KMAX))
            || ((md == MODE_AVG) && (k_r == 3'd3));
  assign empty = (c_r == '0)
              || (h_r < DIMW'(k_r))
              || (w_r < DIMW'(k_r));

  assign hw_p = {{DIMW{1'b0}}, h_r}
              * {{DIMW{1'b0}}, w_r};

  assign row    = {1'b0, hb} + (DIMW+1)'(kh);
  assign col    = {1'b0, wb} + (DIMW+1)'(kw);
  assign rowoff = {{(DIMW){1'b0}}, row}
                * {{(DIMW+1){1'b0}}, w_r};

  assign raddr = ifa + cbase + AW'(rowoff) + AW'(col);
  assign waddr = ofa + n;

  assign rvalid = (st == S_READ);
  assign wvalid = (st == S_WRITE);
  assign busy   = (st != S_IDLE);
  assign done   = (st == S_DONE);

  assign wdata = wvalid
               ? {{(32-DW){res[DW-1]}}, res}
               : 32'd0;

  always_comb begin
    shamt = 3'd0;
    unique case (1'b1)
      (k_r == 3'd4): shamt = 3'd4;
      (k_r == 3'd2): shamt = 3'd2;
      default:       shamt = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      st <= S_IDLE;
    else
      st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE:
        if (start) st_nx = S_CHECK;
      S_CHECK:
        st_nx = (bad || empty) ? S_DONE : S_READ;
      S_READ:
        if (rd_ok && last_tap) st_nx = S_WRITE;
      S_WRITE:
        if (wr_ok)
          st_nx = (!col_more && !row_more && last_ch)
                ? S_DONE : S_READ;
      S_DONE:
        st_nx = S_IDLE;
      default:
        st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md  <= MODE_MAX;
      k_r <= '0;
      s_r <= '0;
      c_r <= '0;
      h_r <= '0;
      w_r <= '0;
      ifa <= '0;
      ofa <= '0;
      err <= 1'b0;
      hw  <= '0;
    end else if (st == S_IDLE && start) begin
      md  <= mode;
      k_r <= K;
      s_r <= S;
      c_r <= C;
      h_r <= H;
      w_r <= W;
      ifa <= ifaddr;
      ofa <= ofaddr;
      err <= 1'b0;
    end else if (st == S_CHECK) begin
      err <= bad;
      hw  <= AW'(hw_p);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch    <= '0;
      hb    <= '0;
      wb    <= '0;
      kh    <= '0;
      kw    <= '0;
      n     <= '0;
      cbase <= '0;
    end else if (st == S_CHECK) begin
      ch    <= '0;
      hb    <= '0;
      wb    <= '0;
      kh    <= '0;
      kw    <= '0;
      n     <= '0;
      cbase <= '0;
    end else if (rd_ok) begin
      if (kw == k_r - 3'd1) begin
        kw <= '0;
        kh <= (kh == k_r - 3'd1) ? 3'd0 : kh + 3'd1;
      end else begin
        kw <= kw + 3'd1;
      end
    end else if (wr_ok) begin
      n <= n + AW'(1);
      if (col_more) begin
        wb <= wb + DIMW'(s_r);
      end else begin
        wb <= '0;
        if (row_more) begin
          hb <= hb + DIMW'(s_r);
        end else begin
          hb    <= '0;
          ch    <= ch + DIMW'(1);
          cbase <= cbase + hw;
        end
      end
    end
  end

  pool_reduce #(
    .DW(DW)
  ) u_reduce (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((st == S_CHECK) || wr_ok),
    .acc   (rd_ok),
    .mode  (md),
    .shamt (shamt),
    .din   (rdata[DW-1:0]),
    .res   (res)
  );

endmodule
